// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit ALU: operand register file, 3-cycle IDLE/EXEC/WB
// sequence per instruction, result write-back and locally derived flags.
module alu_issue_ctrl #(
   parameter int DATA_W = 4,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_r,
   input  logic              alu_cf,
   output logic              done,
   output logic              flag_cf,
   output logic              flag_zf,
   output logic              flag_sf,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREG = 1 << REG_AW;
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_LOADI = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic                accept_s;
   logic                in_ready_s;
   logic                done_s;

   logic [1:0]          op_r;
   logic [REG_AW-1:0]   rd_r;
   logic [DATA_W-1:0]   imm_r;
   logic [DATA_W-1:0]   res_r;
   logic                cf_r;
   logic [DATA_W-1:0]   alu_a_r;
   logic [DATA_W-1:0]   alu_b_r;
   logic [1:0]          alu_op_r;
   logic                flag_cf_r;
   logic                flag_zf_r;
   logic                flag_sf_r;
   logic [DATA_W-1:0]   regs_r [NREG];

   function automatic logic zero_flag(input logic [DATA_W-1:0] value);
      return (value == {DATA_W{1'b0}});
   endfunction

   function automatic logic sign_flag(input logic [DATA_W-1:0] value);
      return value[DATA_W-1];
   endfunction

   assign accept_s = in_valid && (state_r == ST_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: fixed three-cycle occupancy once an instruction is accepted
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = ST_EXEC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EXEC: state_next_s = ST_WB;
         ST_WB:   state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output decode: handshake and retire pulse come straight from the state flops
   always_comb begin
      in_ready_s = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         ST_IDLE: in_ready_s = 1'b1;
         ST_EXEC: in_ready_s = 1'b0;
         ST_WB:   done_s     = 1'b1;
         default: begin
            in_ready_s = 1'b0;
            done_s     = 1'b0;
         end
      endcase
   end

   // Instruction latch and ALU operand registers; operands are read at acceptance,
   // which equals the EXEC-cycle register contents since nothing writes in between
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= 2'b00;
         rd_r     <= {REG_AW{1'b0}};
         imm_r    <= {DATA_W{1'b0}};
         alu_a_r  <= {DATA_W{1'b0}};
         alu_b_r  <= {DATA_W{1'b0}};
         alu_op_r <= 2'b00;
      end else if (accept_s) begin
         op_r     <= in_op;
         rd_r     <= in_rd;
         imm_r    <= in_imm;
         alu_a_r  <= regs_r[in_rs1];
         alu_b_r  <= regs_r[in_rs2];
         alu_op_r <= (in_op == OP_LOADI) ? OP_ADD : in_op;
      end else begin
         op_r     <= op_r;
         rd_r     <= rd_r;
         imm_r    <= imm_r;
         alu_a_r  <= alu_a_r;
         alu_b_r  <= alu_b_r;
         alu_op_r <= alu_op_r;
      end
   end

   // Result capture at the end of EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         res_r <= {DATA_W{1'b0}};
         cf_r  <= 1'b0;
      end else if (state_r == ST_EXEC) begin
         if (op_r == OP_LOADI) begin
            res_r <= imm_r;
            cf_r  <= 1'b0;
         end else begin
            res_r <= alu_r;
            cf_r  <= alu_cf;
         end
      end else begin
         res_r <= res_r;
         cf_r  <= cf_r;
      end
   end

   // Register-file write-back at the end of WB
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (state_r == ST_WB) begin
         regs_r[rd_r] <= res_r;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= regs_r[i];
         end
      end
   end

   // Flag update; LOADI retires without touching the flags
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_cf_r <= 1'b0;
         flag_zf_r <= 1'b0;
         flag_sf_r <= 1'b0;
      end else if ((state_r == ST_WB) && (op_r != OP_LOADI)) begin
         flag_cf_r <= cf_r;
         flag_zf_r <= zero_flag(res_r);
         flag_sf_r <= sign_flag(res_r);
      end else begin
         flag_cf_r <= flag_cf_r;
         flag_zf_r <= flag_zf_r;
         flag_sf_r <= flag_sf_r;
      end
   end

   assign in_ready = in_ready_s;
   assign done     = done_s;
   assign alu_a    = alu_a_r;
   assign alu_b    = alu_b_r;
   assign alu_op   = alu_op_r;
   assign flag_cf  = flag_cf_r;
   assign flag_zf  = flag_zf_r;
   assign flag_sf  = flag_sf_r;
   assign dbg_data = regs_r[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, instruction-level
// reference model, directed scenarios followed by random instruction streams.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [1:0] in_rd;
   logic [1:0] in_rs1;
   logic [1:0] in_rs2;
   logic [3:0] in_imm;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_op;
   logic [3:0] alu_r;
   logic       alu_cf;
   logic       done;
   logic       flag_cf;
   logic       flag_zf;
   logic       flag_sf;
   logic [1:0] dbg_addr;
   logic [3:0] dbg_data;

   int ncmp  = 0;
   int nfail = 0;

   // reference state: architectural registers and flags
   int m_regs [4];
   int m_cf, m_zf, m_sf;

   always #10 clk = ~clk;

   alu_issue_ctrl #(.DATA_W(4), .REG_AW(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_cf(alu_cf),
      .done(done), .flag_cf(flag_cf), .flag_zf(flag_zf), .flag_sf(flag_sf),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // behavioural combinational ALU
   always_comb begin
      logic [4:0] sum;
      sum    = {1'b0, alu_a} + {1'b0, alu_b};
      alu_r  = 4'h0;
      alu_cf = 1'b0;
      case (alu_op)
         2'b00: begin alu_r = sum[3:0]; alu_cf = sum[4]; end
         2'b01: alu_r = alu_a & alu_b;
         2'b10: alu_r = alu_a >> alu_b;
         default: begin alu_r = 4'h0; alu_cf = 1'b0; end
      endcase
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_cf = 0; m_zf = 0; m_sf = 0;
   endtask

   // architectural effect of one instruction, from plain arithmetic
   task automatic model_exec(input int op, input int rd, input int rs1, input int rs2, input int imm);
      int a, b, r;
      a = m_regs[rs1];
      b = m_regs[rs2];
      case (op)
         0: begin
            r    = a + b;
            m_cf = (r > 15) ? 1 : 0;
            r    = r % 16;
         end
         1: begin r = a & b; m_cf = 0; end
         2: begin r = a >> b; m_cf = 0; end
         default: r = imm;
      endcase
      m_regs[rd] = r;
      if (op != 3) begin
         m_zf = (r == 0) ? 1 : 0;
         m_sf = (r >= 8) ? 1 : 0;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_cf"}, 8'(flag_cf), 8'(m_cf));
      chk({tag, "_zf"}, 8'(flag_zf), 8'(m_zf));
      chk({tag, "_sf"}, 8'(flag_sf), 8'(m_sf));
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), 8'(dbg_data), 8'(m_regs[i]));
      end
   endtask

   // called in an IDLE cycle shortly after a rising edge
   task automatic issue(input string tag, input int op, input int rd, input int rs1, input int rs2, input int imm);
      int ea, eb;
      ea = m_regs[rs1];
      eb = m_regs[rs2];
      chk({tag, "_ready_idle"}, 8'(in_ready), 8'd1);
      in_valid = 1'b1;
      in_op = 2'(op); in_rd = 2'(rd); in_rs1 = 2'(rs1); in_rs2 = 2'(rs2); in_imm = 4'(imm);
      model_exec(op, rd, rs1, rs2, imm);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_ready_exec"}, 8'(in_ready), 8'd0);
      chk({tag, "_done_exec"}, 8'(done), 8'd0);
      chk({tag, "_alu_a"}, 8'(alu_a), 8'(ea));
      chk({tag, "_alu_b"}, 8'(alu_b), 8'(eb));
      chk({tag, "_alu_op"}, 8'(alu_op), 8'((op == 3) ? 0 : op));
      in_op = 2'($urandom_range(0, 3)); in_rd = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      chk({tag, "_done_wb"}, 8'(done), 8'd1);
      chk({tag, "_ready_wb"}, 8'(in_ready), 8'd0);
      @(posedge clk); #1;
      chk({tag, "_done_after"}, 8'(done), 8'd0);
      chk({tag, "_alu_a_hold"}, 8'(alu_a), 8'(ea));
      check_state(tag);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t5_op [3];
      int t5_rd [3];
      int dut_acc;
      int op, rd, rs1, rs2, imm;

      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_rd = 2'b00;
      in_rs1 = 2'b00; in_rs2 = 2'b00; in_imm = 4'h0; dbg_addr = 2'b00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", 8'(in_ready), 8'd1);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_alu_a", 8'(alu_a), 8'd0);
      chk("rst_alu_b", 8'(alu_b), 8'd0);
      chk("rst_alu_op", 8'(alu_op), 8'd0);
      check_state("rst");

      // directed scenarios
      issue("t1_li0", 3, 0, 0, 0, 9);
      issue("t1_li1", 3, 1, 0, 0, 3);
      issue("t2_add", 0, 2, 0, 1, 0);
      issue("t3_li0", 3, 0, 0, 0, 15);
      issue("t3_li1", 3, 1, 0, 0, 1);
      issue("t3_add", 0, 3, 0, 1, 0);
      issue("t4_and", 1, 2, 0, 1, 0);
      issue("t4_shr", 2, 3, 0, 1, 0);
      issue("rdeq", 0, 0, 0, 0, 0);

      // in_valid held high across back-to-back instructions
      t5_op = '{0, 1, 2};
      t5_rd = '{2, 3, 2};
      dut_acc = 0;
      in_valid = 1'b1;
      in_rs1 = 2'd0; in_rs2 = 2'd1; in_imm = 4'h0;
      in_op = 2'(t5_op[0]); in_rd = 2'(t5_rd[0]);
      for (int cyc = 0; cyc < 9; cyc++) begin
         chk($sformatf("t5_ready_c%0d", cyc), 8'(in_ready), 8'((cyc % 3 == 0) ? 1 : 0));
         chk($sformatf("t5_done_c%0d", cyc), 8'(done), 8'((cyc % 3 == 2) ? 1 : 0));
         if (cyc % 3 == 0) model_exec(t5_op[cyc / 3], t5_rd[cyc / 3], 0, 1, 0);
         if (in_ready === 1'b1) dut_acc++;
         @(posedge clk); #1;
         if ((cyc % 3 == 0) && (cyc < 6)) begin
            in_op = 2'(t5_op[cyc / 3 + 1]);
            in_rd = 2'(t5_rd[cyc / 3 + 1]);
         end
      end
      in_valid = 1'b0;
      chk("t5_accepted", 8'(dut_acc), 8'd3);
      check_state("t5");

      // reset while an ADD is in EXEC
      in_valid = 1'b1; in_op = 2'b00; in_rd = 2'd1; in_rs1 = 2'd0; in_rs2 = 2'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("t6_done_rst", 8'(done), 8'd0);
      chk("t6_ready_rst", 8'(in_ready), 8'd1);
      chk("t6_alu_a_rst", 8'(alu_a), 8'd0);
      @(posedge clk); #1;
      chk("t6_done_later", 8'(done), 8'd0);
      check_state("t6");
      issue("t6_li", 3, 1, 0, 0, 6);
      issue("t6_add", 0, 2, 1, 1, 0);

      // random instruction stream against the reference model
      for (int n = 0; n < 60; n++) begin
         op  = $urandom_range(0, 3);
         rd  = $urandom_range(0, 3);
         rs1 = $urandom_range(0, 3);
         rs2 = $urandom_range(0, 3);
         imm = $urandom_range(0, 15);
         issue($sformatf("rnd%0d", n), op, rd, rs1, rs2, imm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
